fft_peak_finder: RTL and testbench
==================================

# fft_peak_finder

Downstream stage of the FFT sequencing control. It consumes the complex FFT bins that control drains out of the FFT core, indexed by `output_index`. For each frame it computes the squared magnitude of every eligible bin and reports the index and magnitude of the strongest bin. The per-frame clear comes from control's `reset_max` pulse.

## Interface
- DATA_W, 16, signed width of bin real/imag parts
- IDX_W, 9, bin index width
- N_BINS, 512, FFT length; only bins below N_BINS/2 are eligible
- SKIP_DC, 1, when 1 bin 0 is ineligible
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- reset_max  in  1  synchronous clear of running max and pipeline; aborts current frame
- bin_valid  in  1  bin_re/bin_im/bin_index/bin_last valid this cycle
- bin_index  in  IDX_W  bin number, driven from control's output_index
- bin_re  in  DATA_W  signed real part
- bin_im  in  DATA_W  signed imaginary part
- bin_last  in  1  marks final bin of frame; qualified by bin_valid
- peak_index  out  IDX_W  index of strongest eligible bin, last completed frame
- peak_mag  out  2*DATA_W+1  re²+im² of that bin, unsigned
- peak_valid  out  1  one-cycle pulse when peak_index/peak_mag update
- busy  out  1  high while a frame is in progress or pipeline holds valid data

## Operation
- No backpressure: a bin is accepted on every edge where bin_valid=1, reset=0, and reset_max=0.
- Pipeline:
  - S1 registers re², im², index, eligible, last, first, and valid.
  - S2 registers sum = re²+im², zero-extended to 2*DATA_W+1 bits. Signed multiply; (−2^(DATA_W−1))² must be exact.
  - S3 compares against the running max.
- eligible = (bin_index < N_BINS/2) && !(SKIP_DC && bin_index==0). Ineligible bins flow through the pipeline but never update the max.
- first tag: set on the first accepted bin after reset, after reset_max, or after a bin_last. S3 treats a first bin as starting from max_mag=0, max_idx=0, so back-to-back frames need no gap.
- Update rule: an eligible bin replaces the max only if its sum > max_mag, strictly. Ties keep the earlier-arriving bin.
- Frame close: when S3 processes a bin with last=1:
  - peak_index and peak_mag load the post-compare max, including that bin.
  - peak_valid pulses.
  - If the frame had no eligible bin, or all eligible bins had magnitude 0, outputs are index 0, mag 0.
- peak_index and peak_mag hold between pulses.
- FSM:
  - IDLE → ACTIVE on an accepted bin.
  - ACTIVE → IDLE when S3 closes a frame and no newer bin is in S1/S2 or being accepted.
  - busy = (state==ACTIVE) || any stage valid.
- reset_max:
  - Clears S1/S2/S3 valid bits, the running max, and the first tracking.
  - FSM goes to IDLE.
  - peak_index, peak_mag, and peak_valid are untouched, except that a peak_valid pulse which would occur on that same edge is suppressed.
- reset: same as reset_max, plus peak_index=0, peak_mag=0, peak_valid=0.
- Priority: reset > reset_max > bin_valid.

## Timing
- Reset values: peak_index=0, peak_mag=0, peak_valid=0, busy=0.
- Bin accepted at edge k: S1 valid after k, S2 after k+1, running max updated at edge k+2. If it is last, peak_* and peak_valid=1 change at edge k+2, so peak_valid is visible in cycle k+3 and drops at edge k+3.
- Throughput 1 bin/cycle sustained; frames may abut (bin_last at edge k, next frame's first bin at edge k+1).
- bin_valid with bin_last on a single-bin frame is legal; peak_valid occurs 3 cycles later.
- busy falls at the edge where peak_valid is registered high, if no further bins are in flight.

## Test plan
- Assert reset 5 cycles mid-stream → peak_index=0, peak_mag=0, peak_valid=0, busy=0 on the following cycle; no later pulse from the aborted data.
- Frame of bins 0..511: re=index, im=0, except bin 37 (re=1000, im=−1000); bin_last on 511 → single peak_valid 3 cycles after bin_last, peak_index=37, peak_mag=2000000.
- DC and upper half (SKIP_DC=1): bin 0 re=32767, bin 300 re=30000, bin 5 re=10, all others 0 → peak_index=5, peak_mag=100.
- Tie and extreme values: bins 10 and 20 both re=−300, im=0 → index 10, mag 90000. Next frame, bin 3 re=im=−32768 → mag 2147483648, with no overflow.
- Back-to-back frames: frame A peak at bin 4 (mag 400), frame B starts the cycle after A's bin_last with peak at bin 9 (mag 25) → two pulses 1 frame-length apart reporting (4, 400) then (9, 25); B's result is not contaminated by A.
- reset_max mid-frame: after 100 bins containing mag 1e6 at bin 50, pulse reset_max, then a full frame with peak mag 49 at bin 7 → next pulse reports (7, 49); reset_max asserted together with bin_valid discards that bin.

Source files
------------

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: per-frame peak search over streamed FFT bins.
// Three-stage pipe: square, sum, compare against running max.
module fft_peak_finder #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 9,
  parameter int N_BINS  = 512,
  parameter int SKIP_DC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_max,
  input  logic                     bin_valid,
  input  logic [IDX_W-1:0]         bin_index,
  input  logic signed [DATA_W-1:0] bin_re,
  input  logic signed [DATA_W-1:0] bin_im,
  input  logic                     bin_last,
  output logic [IDX_W-1:0]         peak_index,
  output logic [2*DATA_W:0]        peak_mag,
  output logic                     peak_valid,
  output logic                     busy
);

  localparam int PW = 2 * DATA_W;
  localparam logic [IDX_W:0] HALF = (IDX_W+1)'(N_BINS / 2);
  localparam bit SKIP = (SKIP_DC != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nx;

  logic accept, eligible, first_pend, close;
  logic signed [PW-1:0] re_sq, im_sq;

  logic             s1_valid, s1_elig, s1_last, s1_first;
  logic [IDX_W-1:0] s1_idx;
  logic [PW-1:0]    s1_re2, s1_im2;

  logic             s2_valid, s2_elig, s2_last, s2_first;
  logic [IDX_W-1:0] s2_idx;
  logic [PW:0]      s2_sum;

  logic [IDX_W-1:0] max_idx, base_idx, cand_idx;
  logic [PW:0]      max_mag, base_mag, cand_mag;

  assign accept   = bin_valid && !reset && !reset_max;
  assign re_sq    = bin_re * bin_re;
  assign im_sq    = bin_im * bin_im;
  assign eligible = ({1'b0, bin_index} < HALF) &&
                    !(SKIP && bin_index == '0);
  assign close    = s2_valid && s2_last;

  // S1: squares plus tags; first_pend marks the next bin as a frame start
  always_ff @(posedge clk) begin
    if (reset || reset_max) begin
      s1_valid   <= 1'b0;
      first_pend <= 1'b1;
    end else begin
      s1_valid <= accept;
      if (accept) first_pend <= bin_last;
    end
    if (accept) begin
      s1_re2   <= PW'(re_sq);
      s1_im2   <= PW'(im_sq);
      s1_idx   <= bin_index;
      s1_elig  <= eligible;
      s1_last  <= bin_last;
      s1_first <= first_pend;
    end
  end

  // S2: magnitude sum, one extra bit so two full-scale squares cannot wrap
  always_ff @(posedge clk) begin
    if (reset || reset_max) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
    end
    s2_sum   <= {1'b0, s1_re2} + {1'b0, s1_im2};
    s2_idx   <= s1_idx;
    s2_elig  <= s1_elig;
    s2_last  <= s1_last;
    s2_first <= s1_first;
  end

  // S3 compare: a frame-start bin ignores the previous frame's max
  always_comb begin
    base_mag = s2_first ? '0 : max_mag;
    base_idx = s2_first ? '0 : max_idx;
    cand_mag = base_mag;
    cand_idx = base_idx;
    if (s2_elig && (s2_sum > base_mag)) begin
      cand_mag = s2_sum;
      cand_idx = s2_idx;
    end
  end

  // S3 register: running max and published peak
  always_ff @(posedge clk) begin
    if (reset) begin
      max_mag    <= '0;
      max_idx    <= '0;
      peak_index <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else if (reset_max) begin
      max_mag    <= '0;
      max_idx    <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= close;
      if (s2_valid) begin
        max_mag <= cand_mag;
        max_idx <= cand_idx;
      end
      if (close) begin
        peak_index <= cand_idx;
        peak_mag   <= cand_mag;
      end
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (reset || reset_max) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Frame next-state: stay active while newer bins are still in flight
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACTIVE;
      ACTIVE:  if (close && !s1_valid && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == ACTIVE) || s1_valid || s2_valid;

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: directed frames against a frame-level peak model.
// Model keeps whole frames and searches them when the last bin arrives.
module tb_fft_peak_finder;

  localparam int DATA_W  = 16;
  localparam int IDX_W   = 9;
  localparam int N_BINS  = 512;
  localparam int SKIP_DC = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_max = 1'b0;
  logic bin_valid = 1'b0;
  logic [IDX_W-1:0] bin_index = '0;
  logic signed [DATA_W-1:0] bin_re = '0;
  logic signed [DATA_W-1:0] bin_im = '0;
  logic bin_last = 1'b0;
  logic [IDX_W-1:0] peak_index;
  logic [2*DATA_W:0] peak_mag;
  logic peak_valid;
  logic busy;

  fft_peak_finder #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .N_BINS(N_BINS), .SKIP_DC(SKIP_DC)
  ) dut (
    .clk(clk), .reset(reset), .reset_max(reset_max),
    .bin_valid(bin_valid), .bin_index(bin_index),
    .bin_re(bin_re), .bin_im(bin_im), .bin_last(bin_last),
    .peak_index(peak_index), .peak_mag(peak_mag),
    .peak_valid(peak_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint idx;
    longint mag;
    int     edge_no;
  } ev_t;

  int total = 0;
  int bad = 0;
  int ecnt = 0;
  int last_edge = 0;

  ev_t    pend[$];
  ev_t    plog[$];
  longint fr_idx[$];
  longint fr_mag[$];

  logic   m_pv = 1'b0;
  longint m_idx = 0;
  longint m_mag = 0;
  logic   m_busy = 1'b0;

  logic signed [DATA_W-1:0] re_a[N_BINS];
  logic signed [DATA_W-1:0] im_a[N_BINS];

  task automatic chk(string nm, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Frame model: collect a frame, pick the first strictly-largest eligible bin
  always @(posedge clk) begin
    longint r, im, bi, bm;
    ecnt++;
    if (reset) begin
      pend.delete();
      fr_idx.delete();
      fr_mag.delete();
      m_pv = 1'b0;
      m_idx = 0;
      m_mag = 0;
    end else if (reset_max) begin
      pend.delete();
      fr_idx.delete();
      fr_mag.delete();
      m_pv = 1'b0;
    end else begin
      m_pv = 1'b0;
      if (pend.size() > 0 && pend[0].edge_no == ecnt) begin
        m_pv = 1'b1;
        m_idx = pend[0].idx;
        m_mag = pend[0].mag;
        void'(pend.pop_front());
      end
      if (bin_valid) begin
        r = bin_re;
        im = bin_im;
        fr_idx.push_back(longint'(bin_index));
        fr_mag.push_back(r * r + im * im);
        if (bin_last) begin
          bi = 0;
          bm = 0;
          foreach (fr_idx[i]) begin
            if (fr_idx[i] < N_BINS / 2 &&
                !(SKIP_DC != 0 && fr_idx[i] == 0) &&
                fr_mag[i] > bm) begin
              bi = fr_idx[i];
              bm = fr_mag[i];
            end
          end
          pend.push_back('{bi, bm, ecnt + 2});
          last_edge = ecnt;
          fr_idx.delete();
          fr_mag.delete();
        end
      end
    end
    m_busy = (fr_idx.size() > 0) || (pend.size() > 0);
  end

  // Every-cycle compare against the model, plus a log of observed pulses
  always @(negedge clk) begin
    if (ecnt > 0) begin
      chk("peak_valid", longint'(peak_valid), longint'(m_pv));
      chk("peak_index", longint'(peak_index), m_idx);
      chk("peak_mag", longint'(peak_mag), m_mag);
      chk("busy", longint'(busy), longint'(m_busy));
      if (peak_valid === 1'b1)
        plog.push_back('{longint'(peak_index), longint'(peak_mag), ecnt});
    end
  end

  task automatic clear_bins();
    for (int i = 0; i < N_BINS; i++) begin
      re_a[i] = '0;
      im_a[i] = '0;
    end
  endtask

  task automatic send_frame(int n, bit with_last);
    for (int i = 0; i < n; i++) begin
      bin_valid = 1'b1;
      bin_index = IDX_W'(i);
      bin_re = re_a[i];
      bin_im = im_a[i];
      bin_last = with_last && (i == n - 1);
      @(negedge clk);
    end
    bin_valid = 1'b0;
    bin_last = 1'b0;
  endtask

  task automatic idle(int n);
    bin_valid = 1'b0;
    bin_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pulse(string nm, int k, longint idx, longint mag);
    chk({nm, "_count"}, longint'(plog.size()), longint'(k + 1) > 0 ?
        longint'(plog.size()) + 0 : 0);
  endtask

  task automatic pulse_is(string nm, int k, longint idx, longint mag);
    if (plog.size() > k) begin
      chk({nm, "_idx"}, plog[k].idx, idx);
      chk({nm, "_mag"}, plog[k].mag, mag);
    end else begin
      chk({nm, "_missing"}, longint'(plog.size()), longint'(k + 1));
    end
  endtask

  initial begin
    clear_bins();
    repeat (3) @(negedge clk);
    chk("rst0_idx", longint'(peak_index), 0);
    chk("rst0_mag", longint'(peak_mag), 0);
    chk("rst0_pv", longint'(peak_valid), 0);
    chk("rst0_busy", longint'(busy), 0);
    reset = 1'b0;
    idle(2);

    // Ramp frame with one strong bin; upper half is ineligible
    clear_bins();
    for (int i = 0; i < N_BINS; i++) re_a[i] = DATA_W'(i);
    re_a[37] = 1000;
    im_a[37] = -1000;
    plog.delete();
    send_frame(512, 1'b1);
    idle(5);
    chk("ramp_count", longint'(plog.size()), 1);
    pulse_is("ramp", 0, 37, 2000000);
    if (plog.size() > 0)
      chk("ramp_latency", longint'(plog[0].edge_no - last_edge), 2);

    // Reset mid-stream kills a pending result and clears outputs
    clear_bins();
    for (int i = 0; i < 16; i++) re_a[i] = 100;
    plog.delete();
    send_frame(10, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bin_valid = 1'b1;
      bin_index = IDX_W'(11 + i);
      bin_re = 200;
      bin_im = 0;
      bin_last = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    bin_valid = 1'b0;
    bin_last = 1'b0;
    chk("rst1_idx", longint'(peak_index), 0);
    chk("rst1_mag", longint'(peak_mag), 0);
    chk("rst1_pv", longint'(peak_valid), 0);
    chk("rst1_busy", longint'(busy), 0);
    idle(6);
    chk("rst1_no_pulse", longint'(plog.size()), 0);

    // DC and upper-half bins are ignored
    clear_bins();
    re_a[0] = 32767;
    re_a[300] = 30000;
    re_a[5] = 10;
    plog.delete();
    send_frame(512, 1'b1);
    idle(5);
    chk("dc_count", longint'(plog.size()), 1);
    pulse_is("dc", 0, 5, 100);

    // Tie keeps the earlier bin; then full-scale negative square
    clear_bins();
    re_a[10] = -300;
    re_a[20] = -300;
    plog.delete();
    send_frame(32, 1'b1);
    clear_bins();
    re_a[3] = -32768;
    im_a[3] = -32768;
    send_frame(8, 1'b1);
    idle(5);
    chk("tie_count", longint'(plog.size()), 2);
    pulse_is("tie", 0, 10, 90000);
    pulse_is("ext", 1, 3, 64'd2147483648);

    // Back-to-back frames, second one smaller than the first
    clear_bins();
    re_a[4] = 20;
    plog.delete();
    send_frame(16, 1'b1);
    clear_bins();
    re_a[9] = 5;
    send_frame(16, 1'b1);
    idle(5);
    chk("b2b_count", longint'(plog.size()), 2);
    pulse_is("b2b_a", 0, 4, 400);
    pulse_is("b2b_b", 1, 9, 25);
    if (plog.size() > 1)
      chk("b2b_gap", longint'(plog[1].edge_no - plog[0].edge_no), 16);

    // reset_max aborts a frame and drops a bin offered on the same edge
    clear_bins();
    re_a[50] = 1000;
    plog.delete();
    send_frame(100, 1'b0);
    reset_max = 1'b1;
    bin_valid = 1'b1;
    bin_index = 1;
    bin_re = 30000;
    bin_im = 0;
    @(negedge clk);
    reset_max = 1'b0;
    bin_valid = 1'b0;
    chk("rmax_hold_idx", longint'(peak_index), 9);
    clear_bins();
    re_a[7] = 7;
    send_frame(16, 1'b1);
    idle(5);
    chk("rmax_count", longint'(plog.size()), 1);
    pulse_is("rmax", 0, 7, 49);

    // reset_max on the publishing edge suppresses the pulse
    clear_bins();
    re_a[2] = 3;
    plog.delete();
    send_frame(4, 1'b1);
    idle(1);
    reset_max = 1'b1;
    @(negedge clk);
    reset_max = 1'b0;
    idle(5);
    chk("supp_count", longint'(plog.size()), 0);
    chk("supp_idx", longint'(peak_index), 7);
    chk("supp_mag", longint'(peak_mag), 49);
    chk("supp_busy", longint'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
